send_arbiter: RTL and testbench

SEND_ARBITER -- requirements
Module: send_arbiter

---
 rtl/send_arbiter.sv | 176 +++++++++++++++++
 tb/tb_send_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/send_arbiter.sv
// Round-robin arbiter feeding one sender from three requesters, with timeout
// re-issue, bounded retries, a post-packet idle gap and a saturating loss counter.
module send_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 3,
  parameter int GAP_CYCLES     = 45
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [39:0] req_data0,
  input  logic [39:0] req_data1,
  input  logic [39:0] req_data2,
  output logic [39:0] out_data,
  output logic        out_valid,
  input  logic        data_retrieved,
  input  logic        data_loss,
  output logic [2:0]  ack,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        drop_err,
  output logic [7:0]  loss_count
);

  // state | meaning
  // IDLE  | no owner; arbitrate on req
  // ISSUE | out_valid strobe for the owner's packet
  // WAIT  | waiting for data_retrieved, timeout down-counter running
  // GAP   | mandatory idle after a completed or dropped packet
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0] TMR_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_t        state, state_n;
  logic [1:0]    rr_ptr, rr_n;
  logic [TW-1:0] timer, timer_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic [RW-1:0] retry, retry_n;
  logic [39:0]   out_data_n;
  logic          out_valid_n;
  logic [2:0]    ack_n;
  logic [1:0]    grant_n;
  logic          busy_n;
  logic          drop_n;
  logic          finish;

  logic [1:0]    cand0, cand1, cand2;
  logic [1:0]    pick_idx;
  logic [39:0]   pick_data;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // first requester at or after rr_ptr, wrapping modulo 3
  always_comb begin
    cand0 = rr_ptr;
    cand1 = next_idx(cand0);
    cand2 = next_idx(cand1);
    if (req[cand0])      pick_idx = cand0;
    else if (req[cand1]) pick_idx = cand1;
    else                 pick_idx = cand2;
  end

  always_comb begin
    case (pick_idx)
      2'd1:    pick_data = req_data1;
      2'd2:    pick_data = req_data2;
      default: pick_data = req_data0;
    endcase
  end

  always_comb begin
    state_n     = state;
    rr_n        = rr_ptr;
    timer_n     = timer;
    gap_n       = gap_cnt;
    retry_n     = retry;
    out_data_n  = out_data;
    out_valid_n = 1'b0;
    ack_n       = 3'b000;
    grant_n     = grant;
    drop_n      = 1'b0;
    finish      = 1'b0;

    unique case (state)
      IDLE: begin
        if (|req) begin
          grant_n     = pick_idx;
          out_data_n  = pick_data;
          retry_n     = '0;
          out_valid_n = 1'b1;
          state_n     = ISSUE;
        end
      end
      ISSUE: begin
        if (data_retrieved) begin
          finish = 1'b1;
        end else begin
          timer_n = TMR_LOAD;
          state_n = WAIT;
        end
      end
      WAIT: begin
        // retrieval on the terminal cycle still counts as success
        if (data_retrieved) begin
          finish = 1'b1;
        end else if (timer == '0) begin
          if (retry < RETRY_MAX) begin
            retry_n     = retry + RW'(1);
            out_valid_n = 1'b1;
            state_n     = ISSUE;
          end else begin
            drop_n = 1'b1;
            finish = 1'b1;
          end
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_n = IDLE;
        else               gap_n   = gap_cnt - GW'(1);
      end
    endcase

    if (finish) begin
      ack_n   = 3'b001 << grant;
      rr_n    = next_idx(grant);
      gap_n   = GAP_LOAD;
      state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
    end

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 2'd0;
      timer     <= '0;
      gap_cnt   <= '0;
      retry     <= '0;
      out_data  <= 40'd0;
      out_valid <= 1'b0;
      ack       <= 3'b000;
      grant     <= 2'd0;
      busy      <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_n;
      timer     <= timer_n;
      gap_cnt   <= gap_n;
      retry     <= retry_n;
      out_data  <= out_data_n;
      out_valid <= out_valid_n;
      ack       <= ack_n;
      grant     <= grant_n;
      busy      <= busy_n;
      drop_err  <= drop_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  loss_count <= 8'd0;
    else if (data_loss && loss_count != 8'hFF) loss_count <= loss_count + 8'd1;
  end

endmodule

// File: tb/tb_send_arbiter.sv
// Self-checking bench for send_arbiter: directed transaction table, reset and
// loss-counter sequences, then randomized transactions against a round-robin model.
module tb_send_arbiter;

  localparam int TO = 255;
  localparam int MR = 3;
  localparam int GC = 45;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [39:0] out_data;
  logic        out_valid;
  logic        data_retrieved;
  logic        data_loss;
  logic [2:0]  ack;
  logic [1:0]  grant;
  logic        busy;
  logic        drop_err;
  logic [7:0]  loss_count;
  logic [39:0] dat [3];

  always #5 clk = ~clk;

  send_arbiter #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR), .GAP_CYCLES(GC)) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_data0(dat[0]), .req_data1(dat[1]), .req_data2(dat[2]),
    .out_data(out_data), .out_valid(out_valid),
    .data_retrieved(data_retrieved), .data_loss(data_loss),
    .ack(ack), .grant(grant), .busy(busy), .drop_err(drop_err),
    .loss_count(loss_count)
  );

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;
  int model_loss = 0;
  bit loss_en = 1'b0;

  typedef struct {
    logic [2:0] r;      // request pattern
    int         nf;     // issues that time out before retrieval (>MR: never retrieved)
    int         d;      // retrieval offset from the successful issue's out_valid
    bit         early;  // drop req and scramble data right after first issue
    logic [1:0] g;      // expected grant
    int         iss;    // expected out_valid pulses
    bit         drp;    // expected drop_err
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] model_pick(input logic [2:0] r, input int p);
    for (int k = 0; k < 3; k++)
      if (r[(p + k) % 3]) return 2'((p + k) % 3);
    return 2'd0;
  endfunction

  // Drives one packet from IDLE to the end of its gap; called at a negedge in IDLE.
  task automatic run_txn(input logic [2:0] r, input int nf, input int d, input bit early,
                         input logic [1:0] g, input int iss, input bit drp, input string tag);
    int cyc = 0, n_iss = 0, lat = -1, since = 0, last_iss = 0;
    int acks = 0, drops = 0, gap = 0;
    logic [2:0]  ack_val = 3'b000;
    logic [39:0] exp_data = dat[g];
    req = r;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin
        checks++; errors++;
        $display("FAIL %s bound: no completion after %0d cycles", tag, cyc);
        break;
      end
      if (out_valid) begin
        if (n_iss == 0) lat = cyc;
        else chk($sformatf("%s spacing", tag), cyc - last_iss, TO + 1);
        last_iss = cyc;
        n_iss++;
        since = 0;
        chk($sformatf("%s grant", tag), grant, g);
        chk($sformatf("%s out_data", tag), out_data, exp_data);
        if (early && n_iss == 1) begin
          req = 3'b000;
          dat[g] = ~dat[g];
        end
      end
      if (drop_err) drops++;
      if (ack != 3'b000) begin
        acks++;
        ack_val = ack;
        req = req & ~ack;
      end
      if (acks > 0) begin
        if (busy) gap++;
        else break;
      end
      data_retrieved = (n_iss == nf + 1) && (since == d);
      if (n_iss > 0) since++;
      if (loss_en) begin
        data_loss = ($urandom_range(0, 3) == 0);
        if (data_loss && model_loss < 255) model_loss++;
      end
    end
    data_retrieved = 1'b0;
    data_loss = 1'b0;
    req = 3'b000;
    chk($sformatf("%s latency", tag), lat, 1);
    chk($sformatf("%s issues", tag), n_iss, iss);
    chk($sformatf("%s ack_count", tag), acks, 1);
    chk($sformatf("%s ack", tag), ack_val, 3'b001 << g);
    chk($sformatf("%s drop_err", tag), drops, drp);
    chk($sformatf("%s gap", tag), gap, GC);
    chk($sformatf("%s loss_count", tag), loss_count, model_loss);
    model_ptr = (g + 1) % 3;
  endtask

  initial begin : main
    bit bad;
    int w;
    logic [1:0] eg;
    int nf, d;

    tbl[0]  = '{3'b001, 0,   1,   1'b0, 2'd0, 1, 1'b0};
    tbl[1]  = '{3'b111, 0,   0,   1'b0, 2'd1, 1, 1'b0};
    tbl[2]  = '{3'b111, 0,   0,   1'b0, 2'd2, 1, 1'b0};
    tbl[3]  = '{3'b111, 0,   0,   1'b0, 2'd0, 1, 1'b0};
    tbl[4]  = '{3'b111, 0,   0,   1'b0, 2'd1, 1, 1'b0};
    tbl[5]  = '{3'b010, 4,   0,   1'b0, 2'd1, 4, 1'b1};
    tbl[6]  = '{3'b101, 3,   255, 1'b0, 2'd2, 4, 1'b0};
    tbl[7]  = '{3'b110, 1,   10,  1'b1, 2'd1, 2, 1'b0};
    tbl[8]  = '{3'b011, 0,   2,   1'b0, 2'd0, 1, 1'b0};
    tbl[9]  = '{3'b100, 0,   0,   1'b1, 2'd2, 1, 1'b0};
    tbl[10] = '{3'b011, 0,   0,   1'b0, 2'd0, 1, 1'b0};
    tbl[11] = '{3'b010, 0,   3,   1'b0, 2'd1, 1, 1'b0};

    rst = 1'b1;
    req = 3'b000;
    data_retrieved = 1'b0;
    data_loss = 1'b0;
    dat[0] = 40'd0; dat[1] = 40'd0; dat[2] = 40'd0;
    repeat (3) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset ack", ack, 0);
    chk("reset grant", grant, 0);
    chk("reset out_data", out_data, 0);
    chk("reset drop_err", drop_err, 0);
    chk("reset loss_count", loss_count, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int e = 0; e < 12; e++) begin
      dat[0] = 40'h07_0000_0000 | 40'(e);
      dat[1] = 40'h11_2233_4400 | 40'(e);
      dat[2] = 40'hAA_BBCC_DD00 | 40'(e);
      run_txn(tbl[e].r, tbl[e].nf, tbl[e].d, tbl[e].early, tbl[e].g, tbl[e].iss,
              tbl[e].drp, $sformatf("vec%0d", e));
    end

    // stray data_retrieved while idle must not start or ack anything
    bad = 1'b0;
    data_retrieved = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy || out_valid || ack != 3'b000) bad = 1'b1;
      if (i == 2) data_retrieved = 1'b0;
    end
    chk("idle_retrieved ignored", bad, 0);

    // reset in WAIT for requester 2; rr pointer must restart at 0
    dat[2] = 40'h5A_5A5A_5A5A;
    dat[1] = 40'h12_3456_789A;
    req = 3'b100;
    w = 0;
    while (!out_valid && w < 10) begin @(negedge clk); w++; end
    chk("rst_mid issued", out_valid, 1);
    chk("rst_mid grant", grant, 2);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    req = 3'b000;
    #1;
    chk("rst_mid busy", busy, 0);
    chk("rst_mid out_data", out_data, 0);
    chk("rst_mid grant_zero", grant, 0);
    chk("rst_mid out_valid", out_valid, 0);
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ack != 3'b000 || drop_err) bad = 1'b1;
    end
    rst = 1'b0;
    model_ptr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ack != 3'b000 || drop_err) bad = 1'b1;
    end
    chk("rst_mid no_ack", bad, 0);
    run_txn(3'b110, 0, 0, 1'b0, 2'd1, 1, 1'b0, "rst_regrant");

    // loss counter saturation
    for (int i = 0; i < 300; i++) begin
      data_loss = 1'b1;
      @(negedge clk);
      if (i == 99) chk("loss_count 100", loss_count, 100);
    end
    data_loss = 1'b0;
    chk("loss_count sat", loss_count, 255);
    repeat (3) @(negedge clk);
    chk("loss_count hold", loss_count, 255);
    rst = 1'b1;
    #1 chk("loss_count rst", loss_count, 0);
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    model_loss = 0;
    @(negedge clk);

    // randomized transactions against the round-robin / retry model
    loss_en = 1'b1;
    for (int t = 0; t < 30; t++) begin
      logic [2:0] r;
      bit early;
      r = 3'($urandom_range(1, 7));
      dat[0] = {8'($urandom), 32'($urandom)};
      dat[1] = {8'($urandom), 32'($urandom)};
      dat[2] = {8'($urandom), 32'($urandom)};
      nf = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, MR + 1);
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO) : $urandom_range(0, 3);
      early = 1'($urandom_range(0, 1));
      eg = model_pick(r, model_ptr);
      run_txn(r, nf, d, early, eg, (nf > MR) ? MR + 1 : nf + 1, (nf > MR),
              $sformatf("rnd%0d", t));
    end
    loss_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
